typing_checker: RTL and testbench

- Consumer end of the random-digit generator: on start, snapshots the four 0-9 target digits into a 4-digit challenge.
- Accepts digit keypresses over a valid/ready handshake and compares each against the current target position.
- Counts mistakes and measures elapsed time in prescaled ticks; reports completion to the display/score logic.
- Sits between the random generator and keypad decoder on one side and the seven-segment/score display on the other.

---
 rtl/typing_checker.sv | 155 +++++++++++++++
 tb/tb_typing_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_checker.sv
// typing_checker: takes a 4-digit challenge from the random-digit generator
// and checks keypad digits against it one position at a time. It counts wrong
// keys and measures the round time in prescaled ticks.
// Optional feature: define TYPING_CHECKER_TIMEOUT_EN to end a round once
// elapsed reaches TIMEOUT_TICKS.
module typing_checker #(
    parameter int TICK_DIV      = 100000,
    parameter int TIME_W        = 16,
    parameter int ERR_W         = 8,
    parameter int TIMEOUT_TICKS = 30000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        rand_one,
    input  logic [3:0]        rand_two,
    input  logic [3:0]        rand_three,
    input  logic [3:0]        rand_four,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    output logic              key_ready,
    output logic [15:0]       target,
    output logic [2:0]        pos,
    output logic [ERR_W-1:0]  err_count,
    output logic [TIME_W-1:0] elapsed,
    output logic              hit,
    output logic              miss,
    output logic              busy,
    output logic              done,
    output logic              timed_out
);

    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, TYPING, DONE} state_t;

    state_t             state_q;
    logic [15:0]        target_q;
    logic [2:0]         pos_q;
    logic [ERR_W-1:0]   err_q;
    logic [TIME_W-1:0]  elapsed_q;
    logic [TIME_W-1:0]  elapsed_d;
    logic [PRE_W-1:0]   pre_q;
    logic               hit_q;
    logic               miss_q;
    logic               done_q;
    logic               timed_out_q;

    logic [3:0]         exp_digit;
    logic               xfer;
    logic               tick;
    logic               key_good;
    logic               last_key;

    // Digit expected at the current position; digit 0 sits in the top nibble.
    always_comb begin
        exp_digit = 4'd0;
        case (pos_q)
            3'd0:    exp_digit = target_q[15:12];
            3'd1:    exp_digit = target_q[11:8];
            3'd2:    exp_digit = target_q[7:4];
            3'd3:    exp_digit = target_q[3:0];
            default: exp_digit = 4'd0;
        endcase
    end

    // Handshake, tick and key classification; elapsed_d is the post-tick value.
    always_comb begin
        xfer      = key_valid && (state_q == TYPING);
        tick      = (state_q == TYPING) && (pre_q == PRE_W'(TICK_DIV - 1));
        key_good  = xfer && (key_digit <= 4'd9) && (key_digit == exp_digit);
        last_key  = key_good && (pos_q == 3'd3);
        elapsed_d = elapsed_q;
        if (tick && (elapsed_q != '1)) begin
            elapsed_d = elapsed_q + 1'b1;
        end
    end

    // Round sequencing, scoring and timing with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= 16'h0000;
            pos_q       <= 3'd0;
            err_q       <= '0;
            elapsed_q   <= '0;
            pre_q       <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // Keys arriving here are dropped, including alongside start.
                    if (start) begin
                        target_q    <= {rand_one, rand_two, rand_three, rand_four};
                        pos_q       <= 3'd0;
                        err_q       <= '0;
                        elapsed_q   <= '0;
                        pre_q       <= '0;
                        done_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                        state_q     <= TYPING;
                    end
                end
                TYPING: begin
                    pre_q     <= tick ? '0 : pre_q + 1'b1;
                    elapsed_q <= elapsed_d;
                    if (key_good) begin
                        hit_q <= 1'b1;
                        pos_q <= pos_q + 3'd1;
                        if (last_key) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else if (xfer) begin
                        miss_q <= 1'b1;
                        if (err_q != '1) begin
                            err_q <= err_q + 1'b1;
                        end
                    end
`ifdef TYPING_CHECKER_TIMEOUT_EN
                    // A completing key on the same cycle takes precedence.
                    if (!last_key && (32'(elapsed_d) >= 32'(TIMEOUT_TICKS))) begin
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                        state_q     <= DONE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef TYPING_CHECKER_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_TICKS != 0);
`endif

    assign key_ready = (state_q == TYPING);
    assign busy      = (state_q == TYPING);
    assign target    = target_q;
    assign pos       = pos_q;
    assign err_count = err_q;
    assign elapsed   = elapsed_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_typing_checker.sv
// Bench for typing_checker: directed vector table, hand-written corner
// sequences and randomized rounds checked against a cycle-level reference.
module tb_typing_checker;

    localparam int TICK_DIV      = 4;
    localparam int TIME_W        = 16;
    localparam int ERR_W         = 8;
    localparam int TIMEOUT_TICKS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, key_valid;
    logic [3:0]        rand_one, rand_two, rand_three, rand_four, key_digit;
    logic              key_ready, hit, miss, busy, done, timed_out;
    logic [15:0]       target;
    logic [2:0]        pos;
    logic [ERR_W-1:0]  err_count;
    logic [TIME_W-1:0] elapsed;

    typing_checker #(
        .TICK_DIV(TICK_DIV), .TIME_W(TIME_W), .ERR_W(ERR_W), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rand_one(rand_one), .rand_two(rand_two), .rand_three(rand_three), .rand_four(rand_four),
        .key_valid(key_valid), .key_digit(key_digit), .key_ready(key_ready),
        .target(target), .pos(pos), .err_count(err_count), .elapsed(elapsed),
        .hit(hit), .miss(miss), .busy(busy), .done(done), .timed_out(timed_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: round phase (0 idle, 1 typing, 2 finished), challenge digits,
    // and a count of clock edges spent typing from which elapsed is derived.
    int m_state;
    int m_dig[4];
    int m_pos, m_err, m_cycles;
    int m_hit, m_miss, m_done, m_to;

    function automatic int m_elapsed();
        int e;
        e = m_cycles / TICK_DIV;
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic model_edge();
        m_hit  = 0;
        m_miss = 0;
        if (!rst_n) begin
            m_state = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_pos = 0; m_err = 0; m_cycles = 0; m_done = 0; m_to = 0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state  = 1;
                m_dig[0] = int'(rand_one);
                m_dig[1] = int'(rand_two);
                m_dig[2] = int'(rand_three);
                m_dig[3] = int'(rand_four);
                m_pos = 0; m_err = 0; m_cycles = 0; m_done = 0; m_to = 0;
            end
        end else begin
            m_cycles++;
            if (key_valid) begin
                if (int'(key_digit) <= 9 && int'(key_digit) == m_dig[m_pos]) begin
                    m_hit = 1;
                    m_pos++;
                    if (m_pos == 4) begin
                        m_state = 2;
                        m_done  = 1;
                    end
                end else begin
                    m_miss = 1;
                    if (m_err < 255) m_err++;
                end
            end
`ifdef TYPING_CHECKER_TIMEOUT_EN
            if (m_state == 1 && m_elapsed() >= TIMEOUT_TICKS) begin
                m_state = 2;
                m_done  = 1;
                m_to    = 1;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("target", int'(target), (m_dig[0] << 12) | (m_dig[1] << 8) | (m_dig[2] << 4) | m_dig[3]);
        chk("pos", int'(pos), m_pos);
        chk("err_count", int'(err_count), m_err);
        chk("elapsed", int'(elapsed), m_elapsed());
        chk("hit", int'(hit), m_hit);
        chk("miss", int'(miss), m_miss);
        chk("busy", int'(busy), (m_state == 1) ? 1 : 0);
        chk("key_ready", int'(key_ready), (m_state == 1) ? 1 : 0);
        chk("done", int'(done), m_done);
        chk("timed_out", int'(timed_out), m_to);
    endtask

    // One clock: reference sees the same inputs as the DUT edge, outputs sampled 1 after.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        int st; int kv; int kd;
        int hit; int miss; int pos; int err; int done; int busy; int el;
    } vec_t;

    function automatic vec_t mk(input int st, input int kv, input int kd, input int h, input int m,
                                input int p, input int e, input int d, input int b, input int el);
        vec_t v;
        v.st = st; v.kv = kv; v.kd = kd; v.hit = h; v.miss = m;
        v.pos = p; v.err = e; v.done = d; v.busy = b; v.el = el;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        // start kv kd | hit miss pos err done busy elapsed   (challenge 7,2,9,0)
        tbl[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 1, 7,  1, 0, 1, 0, 0, 1, 0);
        tbl[2]  = mk(0, 1, 2,  1, 0, 2, 0, 0, 1, 0);
        tbl[3]  = mk(0, 1, 9,  1, 0, 3, 0, 0, 1, 0);
        tbl[4]  = mk(0, 1, 0,  1, 0, 4, 0, 1, 0, 1);
        tbl[5]  = mk(0, 1, 7,  0, 0, 4, 0, 1, 0, 1);
        tbl[6]  = mk(1, 1, 7,  0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 1, 7,  1, 0, 1, 0, 0, 1, 0);
        tbl[8]  = mk(0, 1, 5,  0, 1, 1, 1, 0, 1, 0);
        tbl[9]  = mk(0, 1, 2,  1, 0, 2, 1, 0, 1, 0);
        tbl[10] = mk(0, 1, 9,  1, 0, 3, 1, 0, 1, 1);
        tbl[11] = mk(0, 1, 9,  0, 1, 3, 2, 0, 1, 1);
        tbl[12] = mk(0, 1, 0,  1, 0, 4, 2, 1, 0, 1);

        rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        rand_one = 4'd7; rand_two = 4'd2; rand_three = 4'd9; rand_four = 4'd0;
        cycle();
        cycle();
        chk("reset target", int'(target), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset key_ready", int'(key_ready), 0);
        chk("reset done", int'(done), 0);

        // Keys offered while idle are ignored.
        rst_n = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle key_ready", int'(key_ready), 0);
            chk("idle pos", int'(pos), 0);
            chk("idle err", int'(err_count), 0);
        end

        for (int i = 0; i < 13; i++) begin
            start     = (tbl[i].st != 0);
            key_valid = (tbl[i].kv != 0);
            key_digit = 4'(tbl[i].kd);
            cycle();
            chk($sformatf("vec%0d target", i), int'(target), 16'h7290);
            chk($sformatf("vec%0d hit", i), int'(hit), tbl[i].hit);
            chk($sformatf("vec%0d miss", i), int'(miss), tbl[i].miss);
            chk($sformatf("vec%0d pos", i), int'(pos), tbl[i].pos);
            chk($sformatf("vec%0d err", i), int'(err_count), tbl[i].err);
            chk($sformatf("vec%0d done", i), int'(done), tbl[i].done);
            chk($sformatf("vec%0d busy", i), int'(busy), tbl[i].busy);
            chk($sformatf("vec%0d key_ready", i), int'(key_ready), tbl[i].busy);
            chk($sformatf("vec%0d elapsed", i), int'(elapsed), tbl[i].el);
        end

        // Fresh round from DONE, out-of-range key, then a start mid-round.
        rand_one = 4'd1; rand_two = 4'd3; rand_three = 4'd5; rand_four = 4'd8;
        start = 1'b1; key_valid = 1'b0;
        cycle();
        chk("restart target", int'(target), 16'h1358);
        chk("restart err", int'(err_count), 0);
        chk("restart done", int'(done), 0);
        start = 1'b0; key_valid = 1'b1; key_digit = 4'hC;
        cycle();
        chk("keyC miss", int'(miss), 1);
        chk("keyC err", int'(err_count), 1);
        chk("keyC pos", int'(pos), 0);
        key_digit = 4'd1;
        cycle();
        key_digit = 4'd3;
        cycle();
        rand_one = 4'd4; rand_two = 4'd4; rand_three = 4'd4; rand_four = 4'd4;
        start = 1'b1; key_valid = 1'b0;
        cycle();
        chk("midstart target", int'(target), 16'h1358);
        chk("midstart pos", int'(pos), 2);
        chk("midstart busy", int'(busy), 1);
        start = 1'b0; rst_n = 1'b0;
        cycle();
        chk("midreset pos", int'(pos), 0);
        chk("midreset target", int'(target), 0);
        chk("midreset err", int'(err_count), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset hit", int'(hit), 0);
        rst_n = 1'b1;

        rand_one = 4'd6; rand_two = 4'd6; rand_three = 4'd6; rand_four = 4'd6;
        start = 1'b1;
        cycle();
        start = 1'b0;
`ifdef TYPING_CHECKER_TIMEOUT_EN
        for (int i = 0; i < 12; i++) cycle();
        chk("timeout done", int'(done), 1);
        chk("timeout flag", int'(timed_out), 1);
        chk("timeout pos", int'(pos), 0);
`else
        for (int i = 0; i < 100; i++) cycle();
        chk("long busy", int'(busy), 1);
        chk("long elapsed", int'(elapsed), 25);
        key_valid = 1'b1; key_digit = 4'hF;
        for (int i = 0; i < 260; i++) cycle();
        chk("err saturate", int'(err_count), 255);
        chk("err sat pos", int'(pos), 0);
        key_valid = 1'b0;
`endif

        // Randomized rounds with occasional stray starts and resets.
        for (int r = 0; r < 40; r++) begin
            rst_n = 1'b1;
            rand_one   = 4'($urandom_range(0, 9));
            rand_two   = 4'($urandom_range(0, 9));
            rand_three = 4'($urandom_range(0, 9));
            rand_four  = 4'($urandom_range(0, 9));
            start = 1'b1; key_valid = 1'b0;
            cycle();
            for (int c = 0; c < 30; c++) begin
                key_valid = ($urandom_range(0, 3) != 0);
                if (m_state == 1 && $urandom_range(0, 2) != 0)
                    key_digit = 4'(m_dig[m_pos]);
                else
                    key_digit = 4'($urandom_range(0, 15));
                start = ($urandom_range(0, 19) == 0);
                rst_n = ($urandom_range(0, 59) != 0);
                cycle();
            end
        end
        rst_n = 1'b1; start = 1'b0; key_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
